// File: rtl/inst_rom_loader.sv
// Boot-loaded instruction ROM: assembles a big-endian byte stream into 32-bit words, then serves CPU fetches.
// Optional macro ROM_ALIGN_CHECK_EN adds a sticky fetch_misaligned flag and blanks misaligned fetches.
module inst_rom_loader #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rom_ce,
  input  logic [31:0]           rom_address,
  output logic [31:0]           rom_data,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   load_words,
  output logic                  load_overflow
`ifdef ROM_ALIGN_CHECK_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [31:0]       shift_q;
  logic [31:0]       mem [DEPTH];

  logic              accept_c;
  logic              full_c;
  logic              wr_en_c;
  logic [31:0]       word_c;
  logic [ADDR_WIDTH-1:0] rd_idx_c;
  logic              in_range_c;
  logic              fetch_ok_c;

  assign accept_c = load_valid & load_ready;
  assign full_c   = (wr_ptr == PTR_W'(DEPTH));
  assign wr_en_c  = accept_c & ~full_c & (load_last | (byte_cnt == 2'd3));
  assign load_words = wr_ptr;

  // Merge the incoming byte into its big-endian lane; unfilled low lanes stay zero.
  always_comb begin
    word_c = shift_q;
    case (byte_cnt)
      2'd0:    word_c = {load_byte, 24'h0};
      2'd1:    word_c = {shift_q[31:24], load_byte, 16'h0};
      2'd2:    word_c = {shift_q[31:16], load_byte, 8'h0};
      default: word_c = {shift_q[31:8], load_byte};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_LOAD;
      cpu_hold      <= 1'b1;
      load_ready    <= 1'b1;
      byte_cnt      <= 2'd0;
      wr_ptr        <= '0;
      shift_q       <= 32'h0;
      load_overflow <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept_c) begin
            if (full_c) begin
              // Image larger than the array: drop the byte and release the CPU anyway.
              load_overflow <= 1'b1;
              state         <= ST_RUN;
              cpu_hold      <= 1'b0;
              load_ready    <= 1'b0;
            end else if (wr_en_c) begin
              wr_ptr   <= wr_ptr + PTR_W'(1);
              byte_cnt <= 2'd0;
              shift_q  <= 32'h0;
              if (load_last) begin
                state      <= ST_RUN;
                cpu_hold   <= 1'b0;
                load_ready <= 1'b0;
              end
            end else begin
              shift_q  <= word_c;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: begin
          cpu_hold   <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array is never cleared; a reset on the write edge suppresses the write.
  always_ff @(posedge clock) begin
    if (wr_en_c && !reset) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= word_c;
    end
  end

  assign rd_idx_c   = rom_address[ADDR_WIDTH+1:2];
  assign in_range_c = (rom_address[31:2] < 30'(DEPTH));

`ifdef ROM_ALIGN_CHECK_EN
  logic misaligned_c;

  assign misaligned_c = rom_ce & ~cpu_hold & (rom_address[1:0] != 2'b00);
  assign fetch_ok_c   = rom_ce & ~cpu_hold & in_range_c & ~misaligned_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (misaligned_c) begin
      fetch_misaligned <= 1'b1;
    end
  end
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^rom_address[1:0];
  assign fetch_ok_c      = rom_ce & ~cpu_hold & in_range_c;
`endif

  // Zero-latency fetch; anything blocked or out of range reads as 0 (NOP).
  assign rom_data = fetch_ok_c ? mem[rd_idx_c] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: full-size instance plus a DEPTH=4 instance for overflow.
module tb_inst_rom_loader;

  logic        clock;
  logic        reset;

  logic        rom_ce;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        cpu_hold;
  logic [10:0] load_words;
  logic        load_overflow;

  logic        s_rom_ce;
  logic [31:0] s_rom_address;
  logic [31:0] s_rom_data;
  logic        s_load_valid;
  logic [7:0]  s_load_byte;
  logic        s_load_last;
  logic        s_load_ready;
  logic        s_cpu_hold;
  logic [2:0]  s_load_words;
  logic        s_load_overflow;

`ifdef ROM_ALIGN_CHECK_EN
  logic        fetch_misaligned;
  logic        s_fetch_misaligned;
`endif

  inst_rom_loader #(.DEPTH(1024), .ADDR_WIDTH(10)) u_dut (
    .clock(clock), .reset(reset),
    .rom_ce(rom_ce), .rom_address(rom_address), .rom_data(rom_data),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .cpu_hold(cpu_hold),
    .load_words(load_words), .load_overflow(load_overflow)
`ifdef ROM_ALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  inst_rom_loader #(.DEPTH(4), .ADDR_WIDTH(2)) u_small (
    .clock(clock), .reset(reset),
    .rom_ce(s_rom_ce), .rom_address(s_rom_address), .rom_data(s_rom_data),
    .load_valid(s_load_valid), .load_byte(s_load_byte), .load_last(s_load_last),
    .load_ready(s_load_ready), .cpu_hold(s_cpu_hold),
    .load_words(s_load_words), .load_overflow(s_load_overflow)
`ifdef ROM_ALIGN_CHECK_EN
    , .fetch_misaligned(s_fetch_misaligned)
`endif
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] data;
    logic        hold;
    logic [10:0] words;
    logic        ovf;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  logic probe;
  logic mis_exp;
  int   n_cmp;
  int   n_bad;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation whenever the stimulus flags an observation point.
  always @(negedge clock) begin
    exp_t e;
    if (probe) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: observation with empty queue");
      end else begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          cmp({e.name, ".rom_data"},   rom_data,            e.data);
          cmp({e.name, ".cpu_hold"},   32'(cpu_hold),       32'(e.hold));
          cmp({e.name, ".load_ready"}, 32'(load_ready),     32'(e.hold));
          cmp({e.name, ".load_words"}, 32'(load_words),     32'(e.words));
          cmp({e.name, ".overflow"},   32'(load_overflow),  32'(e.ovf));
`ifdef ROM_ALIGN_CHECK_EN
          cmp({e.name, ".misaligned"}, 32'(fetch_misaligned), 32'(e.mis));
`endif
        end else begin
          cmp({e.name, ".rom_data"},   s_rom_data,           e.data);
          cmp({e.name, ".cpu_hold"},   32'(s_cpu_hold),      32'(e.hold));
          cmp({e.name, ".load_ready"}, 32'(s_load_ready),    32'(e.hold));
          cmp({e.name, ".load_words"}, 32'(s_load_words),    32'(e.words));
          cmp({e.name, ".overflow"},   32'(s_load_overflow), 32'(e.ovf));
        end
      end
    end
  end

  task automatic chk(input string nm, input bit sel, input logic [31:0] d,
                     input logic h, input logic [10:0] w, input logic o);
    exp_t e;
    e.name = nm; e.sel = sel; e.data = d; e.hold = h; e.words = w; e.ovf = o; e.mis = mis_exp;
    exp_q.push_back(e);
    probe = 1'b1;
    @(negedge clock);
    #1;
    probe = 1'b0;
  endtask

  task automatic drv(input bit sel, input logic [7:0] b, input logic l);
    if (!sel) begin
      load_valid = 1'b1; load_byte = b; load_last = l;
    end else begin
      s_load_valid = 1'b1; s_load_byte = b; s_load_last = l;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    s_load_valid = 1'b0; s_load_last = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic l);
    drv(sel, b, l);
    tick();
  endtask

  task automatic fetch(input bit sel, input logic ce, input logic [31:0] a);
    if (!sel) begin
      rom_ce = ce; rom_address = a;
    end else begin
      s_rom_ce = ce; s_rom_address = a;
    end
  endtask

  task automatic do_reset();
    rom_ce = 1'b0;
    reset  = 1'b1;
    tick();
    reset   = 1'b0;
    mis_exp = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; probe = 1'b0; mis_exp = 1'b0;
    reset = 1'b1;
    rom_ce = 1'b0; rom_address = 32'h0;
    load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
    s_rom_ce = 1'b0; s_rom_address = 32'h0;
    s_load_valid = 1'b0; s_load_byte = 8'h0; s_load_last = 1'b0;

    // Reset state; fetch is masked while the CPU is held.
    do_reset();
    fetch(0, 1'b1, 32'h0);
    chk("reset", 0, 32'h0, 1'b1, 11'd0, 1'b0);
    chk("s_reset", 1, 32'h0, 1'b1, 11'd0, 1'b0);

    // Eight bytes 01..08, last on the eighth.
    for (int i = 1; i <= 7; i++) send(0, 8'(i), 1'b0);
    drv(0, 8'h08, 1'b1);
    chk("pre_last", 0, 32'h0, 1'b1, 11'd1, 1'b0);
    tick();
    chk("w0", 0, 32'h01020304, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b1, 32'h4);
    chk("w1", 0, 32'h05060708, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b0, 32'h4);
    chk("ce_off", 0, 32'h0, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b1, 32'h0000_1000);
    chk("idx1024", 0, 32'h0, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b1, 32'h8000_0004);
    chk("high_addr", 0, 32'h0, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b1, 32'h6);
`ifdef ROM_ALIGN_CHECK_EN
    mis_exp = 1'b1;
    chk("misaligned", 0, 32'h0, 1'b0, 11'd2, 1'b0);
`else
    chk("lsb_ignored", 0, 32'h05060708, 1'b0, 11'd2, 1'b0);
`endif
    fetch(0, 1'b1, 32'h4);
    tick();
    chk("mis_sticky", 0, 32'h05060708, 1'b0, 11'd2, 1'b0);
    drv(0, 8'hEE, 1'b1);
    tick();
    fetch(0, 1'b1, 32'h0);
    chk("run_ignores", 0, 32'h01020304, 1'b0, 11'd2, 1'b0);

    // Short image AA BB CC is zero-padded.
    do_reset();
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b0);
    drv(0, 8'hCC, 1'b1);
    chk("pad_pre", 0, 32'h0, 1'b1, 11'd0, 1'b0);
    tick();
    fetch(0, 1'b1, 32'h0);
    chk("pad_w0", 0, 32'hAABBCC00, 1'b0, 11'd1, 1'b0);

    // Reset after six bytes: partial second word dropped, restart at word 0.
    do_reset();
    for (int i = 0; i < 6; i++) send(0, 8'(8'hA1 + i), 1'b0);
    do_reset();
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    send(0, 8'h44, 1'b1);
    fetch(0, 1'b1, 32'h0);
    chk("rst_mid_w0", 0, 32'h11223344, 1'b0, 11'd1, 1'b0);
    fetch(0, 1'b1, 32'h4);
    chk("rst_mid_w1", 0, 32'h05060708, 1'b0, 11'd1, 1'b0);

    // Backpressure: one idle cycle between every byte.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(0, 8'(8'hC1 + i), (i == 7));
      if (i != 7) begin
        if (i == 3) chk("gap", 0, 32'h0, 1'b1, 11'd1, 1'b0);
        tick();
      end
    end
    fetch(0, 1'b1, 32'h0);
    chk("bp_w0", 0, 32'hC1C2C3C4, 1'b0, 11'd2, 1'b0);
    fetch(0, 1'b1, 32'h4);
    chk("bp_w1", 0, 32'hC5C6C7C8, 1'b0, 11'd2, 1'b0);

    // DEPTH=4 overflow on the seventeenth byte.
    for (int i = 0; i < 16; i++) send(1, 8'(i), 1'b0);
    chk("s_full", 1, 32'h0, 1'b1, 11'd4, 1'b0);
    send(1, 8'h10, 1'b0);
    fetch(1, 1'b1, 32'h0);
    chk("s_ovf_w0", 1, 32'h00010203, 1'b0, 11'd4, 1'b1);
    fetch(1, 1'b1, 32'hC);
    chk("s_w3", 1, 32'h0C0D0E0F, 1'b0, 11'd4, 1'b1);
    fetch(1, 1'b1, 32'h10);
    chk("s_oob", 1, 32'h0, 1'b0, 11'd4, 1'b1);

    tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
